// File: rtl/andor3_sweep_ctrl_if.sv
// Handshake and gate-side bus between andor3_sweep_ctrl and its requester / andor3 block.
// fail_mask exists only when ANDOR3_FAILMASK_EN is defined.
interface andor3_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       a;
  logic       b;
  logic       c;
  logic       y;
  logic       z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_cnt;
  logic [2:0] first_fail;
  logic       first_fail_vld;
`ifdef ANDOR3_FAILMASK_EN
  logic [7:0] fail_mask;

  modport master (
    output start, abort, y, z,
    input  a, b, c, busy, done, pass, fail_cnt, first_fail, first_fail_vld, fail_mask
  );
  modport slave (
    input  start, abort, y, z,
    output a, b, c, busy, done, pass, fail_cnt, first_fail, first_fail_vld, fail_mask
  );
`else
  modport master (
    output start, abort, y, z,
    input  a, b, c, busy, done, pass, fail_cnt, first_fail, first_fail_vld
  );
  modport slave (
    input  start, abort, y, z,
    output a, b, c, busy, done, pass, fail_cnt, first_fail, first_fail_vld
  );
`endif
endinterface

// File: rtl/andor3_sweep_ctrl.sv
// BIST sequencer: walks all 8 andor3 input vectors, holds each SETTLE cycles, checks y/z.
// Optional per-vector fail bitmap enabled by defining ANDOR3_FAILMASK_EN.
module andor3_sweep_ctrl #(
  parameter int         SETTLE = 2,
  parameter logic [7:0] EXP_Y  = 8'h80,
  parameter logic [7:0] EXP_Z  = 8'hFE
) (
  input logic              clk,
  input logic              rst,
  andor3_sweep_ctrl_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] FIN    = 3'd4;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  logic [2:0] state;
  logic [2:0] vec;
  logic [3:0] settle_cnt;
  logic [2:0] abc;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_cnt;
  logic [2:0] first_fail;
  logic       first_fail_vld;
`ifdef ANDOR3_FAILMASK_EN
  logic [7:0] fail_mask;
`endif

  logic mismatch;
  assign mismatch = (bus.y != EXP_Y[vec]) || (bus.z != EXP_Z[vec]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      vec            <= 3'd0;
      settle_cnt     <= 4'd0;
      abc            <= 3'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= 4'd0;
      first_fail     <= 3'd0;
      first_fail_vld <= 1'b0;
`ifdef ANDOR3_FAILMASK_EN
      fail_mask      <= 8'd0;
`endif
    end else begin
      done <= 1'b0;
      // abort only matters while busy; it takes priority over any sample that cycle
      if (busy && bus.abort) begin
        state <= IDLE;
        abc   <= 3'd0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            abc <= 3'd0;
            if (bus.start && !bus.abort) begin
              state          <= DRIVE;
              vec            <= 3'd0;
              busy           <= 1'b1;
              pass           <= 1'b0;
              fail_cnt       <= 4'd0;
              first_fail     <= 3'd0;
              first_fail_vld <= 1'b0;
`ifdef ANDOR3_FAILMASK_EN
              fail_mask      <= 8'd0;
`endif
            end
          end
          DRIVE: begin
            abc        <= vec;
            settle_cnt <= SETTLE_LD;
            state      <= WAIT;
          end
          WAIT: begin
            if (settle_cnt <= 4'd1) begin
              state <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt - 4'd1;
            end
          end
          SAMPLE: begin
            if (mismatch) begin
              fail_cnt <= fail_cnt + 4'd1;
`ifdef ANDOR3_FAILMASK_EN
              fail_mask[vec] <= 1'b1;
`endif
              if (!first_fail_vld) begin
                first_fail     <= vec;
                first_fail_vld <= 1'b1;
              end
            end
            if (vec == 3'd7) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (fail_cnt == 4'd0) && !mismatch;
            end else begin
              vec   <= vec + 3'd1;
              state <= DRIVE;
            end
          end
          FIN: begin
            abc   <= 3'd0;
            state <= IDLE;
          end
          default: begin
            abc   <= 3'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.a              = abc[2];
  assign bus.b              = abc[1];
  assign bus.c              = abc[0];
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.fail_cnt       = fail_cnt;
  assign bus.first_fail     = first_fail;
  assign bus.first_fail_vld = first_fail_vld;
`ifdef ANDOR3_FAILMASK_EN
  assign bus.fail_mask      = fail_mask;
`endif

endmodule

// File: tb/tb_andor3_sweep_ctrl.sv
// Randomized bench: two controllers (SETTLE=2 and SETTLE=1) beside a faultable andor3 model,
// every cycle compared against a sweep-level reference computed from the sweep rules.
module tb_andor3_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  andor3_sweep_ctrl_if if2();
  andor3_sweep_ctrl_if if1();

  andor3_sweep_ctrl #(.SETTLE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  andor3_sweep_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic       start;
  logic       abort;
  logic       sel;
  logic [7:0] ymask;
  logic [7:0] zmask;

  assign if2.start = start & ~sel;
  assign if1.start = start & sel;
  assign if2.abort = abort & ~sel;
  assign if1.abort = abort & sel;

  // andor3 stand-in: golden y=a&b&c, z=a|b|c, with per-vector fault flips
  assign if2.y = (if2.a & if2.b & if2.c) ^ ymask[{if2.a, if2.b, if2.c}];
  assign if2.z = (if2.a | if2.b | if2.c) ^ zmask[{if2.a, if2.b, if2.c}];
  assign if1.y = (if1.a & if1.b & if1.c) ^ ymask[{if1.a, if1.b, if1.c}];
  assign if1.z = (if1.a | if1.b | if1.c) ^ zmask[{if1.a, if1.b, if1.c}];

  logic [2:0] abc_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [3:0] cnt_o;
  logic [2:0] ff_o;
  logic       ffv_o;
  logic [7:0] mask_o;

  always_comb begin
    abc_o  = sel ? {if1.a, if1.b, if1.c} : {if2.a, if2.b, if2.c};
    busy_o = sel ? if1.busy : if2.busy;
    done_o = sel ? if1.done : if2.done;
    pass_o = sel ? if1.pass : if2.pass;
    cnt_o  = sel ? if1.fail_cnt : if2.fail_cnt;
    ff_o   = sel ? if1.first_fail : if2.first_fail;
    ffv_o  = sel ? if1.first_fail_vld : if2.first_fail_vld;
`ifdef ANDOR3_FAILMASK_EN
    mask_o = sel ? if1.fail_mask : if2.fail_mask;
`else
    mask_o = 8'd0;
`endif
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"},  32'(abc_o),  32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_pass"}, 32'(pass_o), 32'd0);
    check({tag, "_cnt"},  32'(cnt_o),  32'd0);
    check({tag, "_ff"},   32'(ff_o),   32'd0);
    check({tag, "_ffv"},  32'(ffv_o),  32'd0);
`ifdef ANDOR3_FAILMASK_EN
    check({tag, "_mask"}, 32'(mask_o), 32'd0);
`endif
  endtask

  // One sweep; start is high in cycle 0. restart_at/ab_at = cycle of extra start/abort, -1 for none.
  task automatic sweep(input logic s_sel, input logic [7:0] ym, input logic [7:0] zm,
                       input int restart_at, input int ab_at);
    int         per;
    int         endc;
    int         ff;
    logic [7:0] badv;
    logic [7:0] cm;
    logic       aborted;
    sel   = s_sel;
    ymask = ym;
    zmask = zm;
    per   = s_sel ? 3 : 4;
    endc  = 8 * per + 1;
    badv  = ym | zm;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b0;
    for (int t = 1; t <= endc + 2; t++) begin
      @(posedge clk); #1;
      start = (t == restart_at);
      abort = (t == ab_at);
      @(negedge clk);
      // vector k is judged in cycle (k+1)*per and is visible from the next cycle on
      cm = 8'd0;
      for (int k = 0; k < 8; k++)
        if (((k + 1) * per < t) && (ab_at < 0 || (k + 1) * per < ab_at) && badv[k]) cm[k] = 1'b1;
      ff = 0;
      for (int k = 7; k >= 0; k--) if (cm[k]) ff = k;
      aborted = (ab_at >= 0) && (t > ab_at);
      check("busy", 32'(busy_o), 32'(!aborted && t <= 8 * per));
      check("done", 32'(done_o), 32'(!aborted && t == endc));
      check("abc",  32'(abc_o),  (!aborted && t >= 2 && t <= endc) ? 32'((t - 2) / per) : 32'd0);
      check("cnt",  32'(cnt_o),  32'($countones(cm)));
      check("ffv",  32'(ffv_o),  32'(cm != 8'd0));
      check("ff",   32'(ff_o),   32'(ff));
      check("pass", 32'(pass_o), 32'(ab_at < 0 && t >= endc && cm == 8'd0));
`ifdef ANDOR3_FAILMASK_EN
      check("mask", 32'(mask_o), 32'(cm));
`endif
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int         rs;
    int         ab;
    int         per;
    logic       s;
    logic [7:0] ym;
    logic [7:0] zm;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    ymask = 8'd0;
    zmask = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    sweep(1'b0, 8'h00, 8'h00, -1, -1);
    sweep(1'b0, 8'h00, 8'hFE, -1, -1);
    check("zstuck_cnt", 32'(cnt_o), 32'd7);
    check("zstuck_ff",  32'(ff_o),  32'd1);
    sweep(1'b0, 8'h7F, 8'h00, -1, -1);
    check("ystuck_cnt", 32'(cnt_o), 32'd7);
    check("ystuck_ff",  32'(ff_o),  32'd0);
    sweep(1'b0, 8'h00, 8'h00, 10, -1);
    sweep(1'b0, 8'h05, 8'h30, -1, 14);
    sweep(1'b1, 8'h00, 8'h00, -1, -1);

    for (int i = 0; i < 10; i++) begin
      s   = 1'($urandom_range(0, 1));
      per = s ? 3 : 4;
      ym  = 8'($urandom) & 8'($urandom);
      zm  = 8'($urandom) & 8'($urandom);
      rs  = -1;
      ab  = -1;
      if ($urandom_range(0, 3) == 0) begin
        ab = $urandom_range(1, 8 * per);
        if (ab % per == 0) ab = ab - 1;
      end else if ($urandom_range(0, 1) == 1) begin
        rs = $urandom_range(1, 8 * per + 1);
      end
      sweep(s, ym, zm, rs, ab);
    end

    // reset in vector 1 WAIT after vector 0 already failed
    sel   = 1'b0;
    ymask = 8'h00;
    zmask = 8'hFF;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("prerst_cnt", 32'(cnt_o), 32'd1);
    check("prerst_abc", 32'(abc_o), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;

    // start and abort together while idle
    zmask = 8'h00;
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("sa_busy", 32'(busy_o), 32'd0);
      check("sa_abc",  32'(abc_o),  32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
